heart_hit_manager: RTL

HEART_HIT_MANAGER -- requirements
Module: heart_hit_manager

---
 rtl/heart_hit_manager_if.sv | 29 ++
 rtl/heart_hit_manager.sv | 102 ++++++++++
 2 files changed

// File: rtl/heart_hit_manager_if.sv
// heart_hit_manager_if: scan position, sprite overlap and hit/HP status bundle.
`default_nettype none

interface heart_hit_manager_if #(
    parameter int NUM_BULLETS = 4
);
    logic [3:0]             state;
    logic [9:0]             x;
    logic [9:0]             y;
    logic                   heart_on;
    logic [NUM_BULLETS-1:0] bullet_on;
    logic [NUM_BULLETS-1:0] collision;
    logic [4:0]             hp;
    logic                   invuln;
    logic                   hit_flash;
    logic                   game_over;

    modport master (
        output state, x, y, heart_on, bullet_on,
        input  collision, hp, invuln, hit_flash, game_over
    );

    modport slave (
        input  state, x, y, heart_on, bullet_on,
        output collision, hp, invuln, hit_flash, game_over
    );
endinterface

`default_nettype wire

// File: rtl/heart_hit_manager.sv
// ============================================================================
// Module  : heart_hit_manager
// Brief   : Per-frame heart/bullet collision capture, HP, invulnerability and
//           game-over tracking. Optional macro HEART_HIT_FLASH_EN adds a blink.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module heart_hit_manager #(
    parameter int NUM_BULLETS   = 4,
    parameter int MAX_HP        = 20,
    parameter int DAMAGE        = 5,
    parameter int INVULN_FRAMES = 30
) (
    input  wire logic          clk,
    input  wire logic          reset,
    heart_hit_manager_if.slave bus
);

    localparam int             CW        = $clog2(INVULN_FRAMES + 1);
    localparam logic [4:0]     c_MAX_HP  = 5'(MAX_HP);
    localparam logic [4:0]     c_DAMAGE  = 5'(DAMAGE);
    localparam logic [CW-1:0]  c_INVULN  = CW'(INVULN_FRAMES);
    localparam logic [CW-1:0]  c_CNT_ONE = CW'(1);

    logic [NUM_BULLETS-1:0] r_pending;
    logic [NUM_BULLETS-1:0] r_collision;
    logic [4:0]             r_hp;
    logic [CW-1:0]          r_cnt;
    logic                   r_invuln;
    logic                   r_game_over;

    logic                   w_battle;
    logic                   w_frame_end;
    logic [NUM_BULLETS-1:0] w_hits;
    logic                   w_damage;
    logic [4:0]             w_hp_dmg;

    assign w_battle    = (bus.state == 4'd1);
    assign w_frame_end = w_battle && (bus.x == 10'd639) && (bus.y == 10'd479);
    // The frame-end pixel itself still contributes to this frame's hits.
    assign w_hits      = r_pending | ((w_battle && bus.heart_on) ? bus.bullet_on : '0);
    assign w_damage    = (|w_hits) && (r_cnt == '0) && !r_game_over;
    assign w_hp_dmg    = (r_hp > c_DAMAGE) ? (r_hp - c_DAMAGE) : 5'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_collision <= '0;
            r_hp        <= c_MAX_HP;
            r_cnt       <= '0;
            r_invuln    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_collision <= '0;
            if (!w_battle) begin
                r_pending <= '0;
            end else if (w_frame_end) begin
                r_pending   <= '0;
                r_collision <= w_hits;
                if (w_damage) begin
                    r_hp     <= w_hp_dmg;
                    r_cnt    <= c_INVULN;
                    r_invuln <= (c_INVULN != '0);
                    if (w_hp_dmg == 5'd0) begin
                        r_game_over <= 1'b1;
                    end
                end else if (!r_game_over && (r_cnt != '0)) begin
                    r_cnt    <= r_cnt - c_CNT_ONE;
                    r_invuln <= (r_cnt != c_CNT_ONE);
                end
            end else begin
                r_pending <= w_hits;
            end
        end
    end

    assign bus.collision = r_collision;
    assign bus.hp        = r_hp;
    assign bus.invuln    = r_invuln;
    assign bus.game_over = r_game_over;

`ifdef HEART_HIT_FLASH_EN
    logic [2:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 3'd1;
        end
    end

    // Bit 2 toggles every 4 frames, giving an 8-frame blink period.
    assign bus.hit_flash = r_invuln & r_frame_cnt[2];
`else
    assign bus.hit_flash = 1'b0;
`endif

endmodule

`default_nettype wire
